// File: rtl/bcd_digit_scanner_if.sv
// Display-side bundle of the BCD digit scanner: counter-chain inputs plus the
// multiplexed segment, decimal-point and digit-enable outputs.
interface bcd_digit_scanner_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic                dir_in;
    logic                tc_in;
    logic                lzb;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output digits_in, dir_in, tc_in, lzb,
        input  seg, dp, an
    );

    modport slave (
        input  digits_in, dir_in, tc_in, lzb,
        output seg, dp, an
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed 7-segment driver for a BCD counter chain with per-frame snapshot,
// leading-zero blanking, invalid-code dash and a stretched terminal-count indicator.
module bcd_digit_scanner #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_digit_scanner_if.slave      bus
);

    localparam int unsigned PcW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PcW-1:0]      pc_q, pc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic                snap_dir_q, snap_dir_d;
    logic [3:0]          hold_q, hold_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                frame_start;
    logic [DIGITS-1:0]   blank;
    logic                zero_run;
    logic [3:0]          cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Scan timing and snapshot capture
    always_comb begin
        tick        = (pc_q == PcW'(PRESCALE - 1));
        frame_start = tick && (idx_q == IdxW'(DIGITS - 1));
        pc_d        = tick ? '0 : pc_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        snap_dig_d = frame_start ? bus.digits_in : snap_dig_q;
        snap_dir_d = frame_start ? bus.dir_in    : snap_dir_q;
    end

    // Reload on tc_in beats the frame-start decrement
    always_comb begin
        hold_d = hold_q;
        if (bus.tc_in) begin
            hold_d = 4'(HOLD_FRAMES);
        end else if (frame_start && (hold_q != 4'd0)) begin
            hold_d = hold_q - 4'd1;
        end
    end

    // Digit k is blank when it and every higher snapshot digit are zero
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run = zero_run & (snap_dig_d[4*k +: 4] == 4'd0);
            blank[k] = zero_run;
        end
    end

    // Outputs are built from the next-state snapshot so frame start needs no extra cycle
    always_comb begin
        cur_digit = snap_dig_d[4*int'(idx_d) +: 4];
        seg_d     = seg_q;
        an_d      = an_q;
        dp_d      = dp_q;
        if (tick) begin
            seg_d       = (bus.lzb && blank[idx_d]) ? 7'h00 : seg_decode(cur_digit);
            an_d        = '0;
            an_d[idx_d] = 1'b1;
            if (idx_d == '0) begin
                dp_d = (hold_q != 4'd0);
            end else if (idx_d == IdxW'(DIGITS - 1)) begin
                dp_d = snap_dir_d;
            end else begin
                dp_d = 1'b0;
            end
        end else if (an_q[0]) begin
            dp_d = (hold_q != 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            idx_q      <= IdxW'(DIGITS - 1);
            snap_dig_q <= '0;
            snap_dir_q <= 1'b0;
            hold_q     <= 4'd0;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            an_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_dir_q <= snap_dir_d;
            hold_q     <= hold_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Multiplexed 7-segment display driver for the chain of BCD up/down digit counters. Each counter publishes a 4-bit digit, a direction bit (1 = counting down) and a terminal-count flag. This block consumes those signals and time-multiplexes them onto one shared segment bus with one-hot digit enables. A frame snapshot keeps a display scan tear-free. It also adds leading-zero blanking, invalid-code indication and a stretched terminal-count indicator.

## Interface
- DIGITS, 4: number of digits scanned (2..8).
- PRESCALE, 1000: clk cycles each digit is enabled (≥2).
- HOLD_FRAMES, 2: full frames the terminal-count indicator stays lit after tc_in last seen high (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- digits_in  in  4*DIGITS  BCD digits; [3:0] = digit 0 (least significant).
- dir_in  in  1  count direction of the chain, 1 = down.
- tc_in  in  1  terminal-count level from the least-significant counter.
- lzb  in  1  leading-zero blanking enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- dp  out  1  decimal point, active-high, registered.
- an  out  DIGITS  one-hot digit enable, active-high, registered.

## Operation
- Prescaler pc counts 0..PRESCALE-1 and wraps. A tick is the cycle with pc==PRESCALE-1.
- Digit index idx advances on each tick, with DIGITS-1 wrapping to 0. A tick moving idx to 0 is a frame start.
- Frame start captures digits_in and dir_in into the snapshot. All displayed digit and direction values come from the snapshot, so a frame never mixes values.
- Segment codes:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Codes A–F (invalid) show 40, a dash.
  - A blanked digit shows 00.
- Blanking applies only when lzb=1. Digit k≥1 is blanked when snapshot digit k and every higher digit are 0. Digit 0 is never blanked. Invalid codes count as nonzero.
- dp on digit DIGITS-1 equals the snapshot dir_in.
- dp on digit 0 equals tc_flag, where tc_flag = (hold≠0).
  - hold is a 4-bit counter. It reloads to HOLD_FRAMES on any cycle with tc_in=1.
  - Otherwise it decrements by 1 at each frame start while nonzero.
  - If tc_in=1 coincides with a frame start, the reload wins.
- dp on all other digits is 0.
- an has exactly one bit set, an[idx], from the first tick after reset onward.

## Timing
- Reset values: seg=00, dp=0, an=0, pc=0, idx=DIGITS-1, snapshot=0, hold=0.
- The first tick after reset is the rising edge ending cycle PRESCALE-1 after reset release. It is a frame start.
  - Snapshot captures the inputs at that edge.
  - seg, dp and an update at that same edge for digit 0, using the newly captured values (bypass mux; no extra cycle).
- seg, dp and an change only on tick edges.
  - Exception: hold changes can alter dp on digit 0 mid-dwell. dp follows hold with 1 cycle latency, since dp is registered from hold.
- Each digit is enabled for exactly PRESCALE cycles. The frame period is DIGITS×PRESCALE cycles.
- Changes to digits_in or dir_in between frame starts have no visible effect until the next frame start.
- tc_in is sampled every cycle. A single-cycle pulse is never lost.
- Asynchronous reset mid-frame immediately forces all outputs to reset values. Scanning restarts from the first-tick rule above.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=4, HOLD_FRAMES=2.
- **Reset and scan order.** Release rst_n with digits_in=16'h1234.
  - an=0 and seg=00 for cycles 0..2.
  - At the edge ending cycle 3: an=0001, seg=66 (digit "4").
  - Then every 4 cycles: an=0010/seg=4F, an=0100/seg=5B, an=1000/seg=06, then back to an=0001.
- **Snapshot.** Change digits_in from 16'h1234 to 16'h5678 while an=0010.
  - The rest of the frame still shows 3, 2, 1.
  - The next frame shows 8, 7, 6, 5 (7F, 07, 7D, 6D).
- **Leading-zero blanking.** digits_in=16'h0070, lzb=1: digits 3 and 2 show 00, digit 1 shows 07, digit 0 shows 3F.
  - With lzb=0, digits 3 and 2 show 3F.
  - digits_in=16'h0000 with lzb=1 shows 00, 00, 00, 3F.
- **Invalid code.** digits_in=16'h00A9, lzb=1: digit 1 shows 40, digit 0 shows 6F, digits 3 and 2 show 00.
- **Terminal-count stretch.** Pulse tc_in high for 1 cycle mid-frame.
  - dp is high on every digit-0 slot for the remainder of that frame plus 2 subsequent frame starts' worth.
  - hold reaches 0 at the second frame start after the pulse, and the digit-0 dp is then 0.
  - Holding tc_in=1 across a frame start keeps hold at 2.
- **Direction and async reset.** dir_in=1: dp=1 only while an=1000.
  - Asserting rst_n=0 mid-dwell immediately gives seg=00, dp=0, an=0, independent of clk.
